// File: rtl/image_pipe_pkg.sv
// Shared types and widths for the image pipeline frame sequencer.
package image_pipe_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_VS, ARM, ACTIVE} state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int TIMEOUT_W   = 24;

endpackage

// File: rtl/frame_geom_checker.sv
// Pixel/line counters for an admitted frame; emits single-cycle geometry error pulses.
module frame_geom_checker #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             arm,
  input  logic             hr_d,
  input  logic             ck_d,
  input  logic             hr_fall,
  input  logic             vs_rise,
  output logic [CNT_W-1:0] line_cnt,
  output logic             hsize_err,
  output logic             vsize_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HD      = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] VD      = CNT_W'(IMG_VDISP);

  logic [CNT_W-1:0] pix_cnt;
  logic             line_end;

  // A line cut short by vsync is dropped rather than checked.
  assign line_end  = active & hr_fall & ~vs_rise;
  assign hsize_err = line_end & ((pix_cnt != HD) | (pix_cnt == CNT_MAX));
  assign vsize_err = active & vs_rise & ((line_cnt != VD) | (line_cnt == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (arm) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (active) begin
      if (line_end) begin
        pix_cnt <= '0;
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
      end else if (hr_d && ck_d && pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_pipe_frame_ctrl.sv
// Whole-frame admission sequencer: gates vsync/href/clken and reports frame status.
// Optional watchdog built when IMAGE_PIPE_FRAME_TIMEOUT_EN is defined.
module image_pipe_frame_ctrl
  import image_pipe_pkg::*;
#(
  parameter int                   IMG_HDISP   = 640,
  parameter int                   IMG_VDISP   = 480,
  parameter int                   CNT_W       = 12,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'd8_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   per_frame_clken,
  input  logic                   cfg_enable,
  input  logic                   err_clr,
  output logic                   proc_frame_vsync,
  output logic                   proc_frame_href,
  output logic                   proc_frame_clken,
  output logic                   frame_active,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0]       line_cnt,
  output logic                   err_hsize,
  output logic                   err_vsize,
  output logic                   err_timeout
);

  state_t state, state_nxt;
  logic   vs_d, hr_d, ck_d, vs_q, hr_q;
  logic   vs_rise, vs_fall, hr_fall;
  logic   in_arm, in_active, timeout, frame_end;
  logic   hsize_err, vsize_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      hr_d <= 1'b0;
      ck_d <= 1'b0;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_d <= per_frame_vsync;
      hr_d <= per_frame_href;
      ck_d <= per_frame_clken;
      vs_q <= vs_d;
      hr_q <= hr_d;
    end
  end

  assign vs_rise   = vs_d & ~vs_q;
  assign vs_fall   = ~vs_d & vs_q;
  assign hr_fall   = ~hr_d & hr_q;
  assign in_arm    = (state == ARM);
  assign in_active = (state == ACTIVE);

`ifdef IMAGE_PIPE_FRAME_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog;

  assign timeout = (in_arm | in_active) & (wdog == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!(in_arm || in_active) || vs_rise || vs_fall || timeout) wdog <= '0;
      else                                                        wdog <= wdog + 1'b1;
      err_timeout <= timeout | (err_timeout & ~err_clr);
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (cfg_enable) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!cfg_enable)  state_nxt = IDLE;
        else if (vs_rise) state_nxt = ARM;
      end
      ARM: begin
        if (timeout)      state_nxt = WAIT_VS;
        else if (vs_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (timeout) begin
          state_nxt = WAIT_VS;
        end else if (vs_rise) begin
          frame_end = 1'b1;
          state_nxt = cfg_enable ? ARM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated outputs: one cycle behind the raw inputs, href cut on frame end.
  assign proc_frame_vsync = vs_d & (in_arm | in_active) & ~timeout;
  assign proc_frame_href  = hr_d & in_active & ~vs_rise & ~timeout;
  assign proc_frame_clken = ck_d & in_active & ~timeout;
  assign frame_active     = in_active;

  frame_geom_checker #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .CNT_W     (CNT_W)
  ) u_geom (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (in_active),
    .arm       (in_arm),
    .hr_d      (hr_d),
    .ck_d      (ck_d),
    .hr_fall   (hr_fall),
    .vs_rise   (vs_rise),
    .line_cnt  (line_cnt),
    .hsize_err (hsize_err),
    .vsize_err (vsize_err)
  );

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_hsize  <= 1'b0;
      err_vsize  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      err_hsize  <= hsize_err | (err_hsize & ~err_clr);
      err_vsize  <= vsize_err | (err_vsize & ~err_clr);
    end
  end

endmodule

// File: tb/tb_image_pipe_frame_ctrl.sv
// Directed bench for image_pipe_frame_ctrl using a small 8x6 frame geometry.
module tb_image_pipe_frame_ctrl;

  localparam int HD = 8;
  localparam int VD = 6;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic          cfg_enable = 1'b0, err_clr = 1'b0;
  logic          proc_frame_vsync, proc_frame_href, proc_frame_clken;
  logic          frame_active, frame_done;
  logic [15:0]   frame_cnt;
  logic [CW-1:0] line_cnt;
  logic          err_hsize, err_vsize, err_timeout;

  image_pipe_frame_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .cfg_enable       (cfg_enable),
    .err_clr          (err_clr),
    .proc_frame_vsync (proc_frame_vsync),
    .proc_frame_href  (proc_frame_href),
    .proc_frame_clken (proc_frame_clken),
    .frame_active     (frame_active),
    .frame_done       (frame_done),
    .frame_cnt        (frame_cnt),
    .line_cnt         (line_cnt),
    .err_hsize        (err_hsize),
    .err_vsize        (err_vsize),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int gate_bad = 0, href_seen = 0, done_seen = 0, to_seen = 0;
  logic tb_vs, tb_hr, tb_ck;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tb_vs <= 1'b0; tb_hr <= 1'b0; tb_ck <= 1'b0;
    end else begin
      tb_vs <= per_frame_vsync; tb_hr <= per_frame_href; tb_ck <= per_frame_clken;
    end

  always @(negedge clk)
    if (rst_n) begin
      if (frame_active) begin
        if (proc_frame_href !== tb_hr || proc_frame_clken !== tb_ck || proc_frame_vsync !== tb_vs)
          gate_bad++;
      end else if (proc_frame_href || proc_frame_clken) begin
        gate_bad++;
      end
      if (proc_frame_href) href_seen++;
      if (frame_done)      done_seen++;
      if (err_timeout)     to_seen++;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic vs, input logic hr, input logic ck);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
  endtask

  task automatic vs_pulse();
    set_in(1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    set_in(1'b0, 1'b0, 1'b0);
  endtask

  // clr raises err_clr on the cycle the line-end check is made.
  task automatic line(input int pix, input logic clr);
    set_in(1'b0, 1'b1, 1'b1);
    repeat (pix) tick();
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    err_clr = clr;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic body(input int lines, input int bad_line, input int bad_pix);
    set_in(1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    for (int i = 0; i < lines; i++) line((i == bad_line) ? bad_pix : HD, 1'b0);
    repeat (2) tick();
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  typedef struct {
    int   lines;
    int   bad_line;
    int   bad_pix;
    logic exp_h;
    logic exp_v;
  } vec_t;

  vec_t vecs[6];
  int   exp_fc, d0, h0;

  initial begin
    vecs[0] = '{VD,     -1, 0,      1'b0, 1'b0};
    vecs[1] = '{VD,      2, HD - 1, 1'b1, 1'b0};
    vecs[2] = '{VD - 1, -1, 0,      1'b0, 1'b1};
    vecs[3] = '{VD,      0, HD + 1, 1'b1, 1'b0};
    vecs[4] = '{VD + 1, -1, 0,      1'b0, 1'b1};
    vecs[5] = '{VD,     -1, 0,      1'b0, 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst_proc", {proc_frame_vsync, proc_frame_href, proc_frame_clken}, 0);
    chk("rst_status", {frame_active, frame_done, err_hsize, err_vsize, err_timeout}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_cnt", line_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Three clean frames
    cfg_enable = 1'b1;
    tick();
    d0 = done_seen; h0 = href_seen;
    vs_pulse();
    for (int f = 0; f < 3; f++) begin
      body(VD, -1, 0);
      vs_pulse();
    end
    exp_fc = 3;
    chk("three_done", done_seen - d0, 3);
    chk("three_frame_cnt", frame_cnt, exp_fc);
    chk("three_errs", {err_hsize, err_vsize}, 0);
    chk("three_href", href_seen - h0, 3 * VD * HD);

    // Geometry table
    for (int k = 0; k < 6; k++) begin
      clr_pulse();
      body(vecs[k].lines, vecs[k].bad_line, vecs[k].bad_pix);
      chk($sformatf("vec%0d_line_cnt", k), line_cnt, vecs[k].lines);
      d0 = done_seen;
      vs_pulse();
      exp_fc++;
      chk($sformatf("vec%0d_err_hsize", k), err_hsize, vecs[k].exp_h);
      chk($sformatf("vec%0d_err_vsize", k), err_vsize, vecs[k].exp_v);
      chk($sformatf("vec%0d_frame_cnt", k), frame_cnt, exp_fc);
      chk($sformatf("vec%0d_done", k), done_seen - d0, 1);
    end

    // Short line, clear, then clear colliding with a long line end
    clr_pulse();
    tick();
    line(HD - 1, 1'b0);
    chk("short_line_err", err_hsize, 1);
    clr_pulse();
    chk("after_clr", err_hsize, 0);
    line(HD + 1, 1'b1);
    chk("clr_vs_new_err", err_hsize, 1);
    for (int i = 0; i < VD - 2; i++) line(HD, 1'b0);
    repeat (2) tick();
    vs_pulse();
    exp_fc++;
    chk("clr_seq_vsize", err_vsize, 0);
    chk("clr_seq_frame_cnt", frame_cnt, exp_fc);

    // Disable mid-frame: frame completes, then nothing is admitted
    clr_pulse();
    tick();
    line(HD, 1'b0); line(HD, 1'b0);
    cfg_enable = 1'b0;
    for (int i = 0; i < VD - 2; i++) line(HD, 1'b0);
    repeat (2) tick();
    d0 = done_seen;
    vs_pulse();
    exp_fc++;
    chk("dis_done", done_seen - d0, 1);
    chk("dis_frame_cnt", frame_cnt, exp_fc);
    chk("dis_err_vsize", err_vsize, 0);
    chk("dis_idle_vsync", {frame_active, proc_frame_vsync}, 0);
    h0 = href_seen; d0 = done_seen;
    body(VD, -1, 0);
    vs_pulse();
    chk("dis_next_href", href_seen - h0, 0);
    chk("dis_next_done", done_seen - d0, 0);

    // Enable mid-frame: partial frame dropped
    h0 = href_seen; d0 = done_seen;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    line(HD, 1'b0); line(HD, 1'b0);
    cfg_enable = 1'b1;
    for (int i = 0; i < VD - 2; i++) line(HD, 1'b0);
    repeat (2) tick();
    vs_pulse();
    chk("en_partial_href", href_seen - h0, 0);
    chk("en_partial_done", done_seen - d0, 0);
    h0 = href_seen;
    body(VD, -1, 0);
    vs_pulse();
    exp_fc++;
    chk("en_full_done", done_seen - d0, 1);
    chk("en_full_href", href_seen - h0, VD * HD);
    chk("en_frame_cnt", frame_cnt, exp_fc);

    // Reset mid-frame
    clr_pulse();
    tick();
    line(HD - 1, 1'b0);
    line(HD, 1'b0);
    chk("pre_rst_err", err_hsize, 1);
    set_in(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_proc", {proc_frame_vsync, proc_frame_href, proc_frame_clken}, 0);
    chk("mid_rst_status", {frame_active, frame_done, err_hsize, err_vsize}, 0);
    chk("mid_rst_cnts", {frame_cnt, line_cnt}, 0);
    tick();
    rst_n = 1'b1;
    h0 = href_seen;
    for (int i = 0; i < VD - 3; i++) line(HD, 1'b0);
    repeat (2) tick();
    chk("post_rst_href", href_seen - h0, 0);
    vs_pulse();
    body(VD, -1, 0);
    vs_pulse();
    chk("post_rst_frame_cnt", frame_cnt, 1);
    chk("post_rst_errs", {err_hsize, err_vsize}, 0);

    chk("gating_errors", gate_bad, 0);
    chk("no_timeout", to_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
